// File: rtl/sdram_av_pkg.sv
// sdram_av_pkg: FSM encoding and default widths shared by the SDRAM Avalon master.
package sdram_av_pkg;
    typedef enum logic {IDLE, ISSUE} av_state_t;
    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 32;
endpackage

// File: rtl/sdram_av_master_if.sv
// sdram_av_master_if: command, response and Avalon sdram_s1 signals of the SDRAM master.
interface sdram_av_master_if
    import sdram_av_pkg::*;
#(
    parameter int ADDR_W   = SDRAM_ADDR_W,
    parameter int DATA_W   = SDRAM_DATA_W,
    parameter int MAX_PEND = 4
);
    localparam int BE_W = DATA_W / 8;
    localparam int PW   = $clog2(MAX_PEND + 1);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [PW-1:0]     pending;
    logic              busy;
    logic [ADDR_W-1:0] av_address;
    logic [BE_W-1:0]   av_byteenable_n;
    logic              av_chipselect;
    logic [DATA_W-1:0] av_writedata;
    logic              av_read_n;
    logic              av_write_n;
    logic [DATA_W-1:0] av_readdata;
    logic              av_readdatavalid;
    logic              av_waitrequest;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
               av_readdata, av_readdatavalid, av_waitrequest,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, pending, busy,
               av_address, av_byteenable_n, av_chipselect, av_writedata, av_read_n, av_write_n
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be,
               av_readdata, av_readdatavalid, av_waitrequest,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, pending, busy,
               av_address, av_byteenable_n, av_chipselect, av_writedata, av_read_n, av_write_n
    );
endinterface

// File: rtl/sdram_av_master.sv
// sdram_av_master: turns single-word valid/ready commands into waitrequest-aware Avalon
// transfers and tracks outstanding reads against readdatavalid.
module sdram_av_master
    import sdram_av_pkg::*;
#(
    parameter int MAX_PEND = 4
) (
    input logic               clk,
    input logic               reset,
    sdram_av_master_if.master bus
);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
    av_state_t state;
    logic      rd_done;
    logic      rsp_dec;
    assign rd_done = state == ISSUE && !bus.av_waitrequest && bus.av_write_n;
    // a return that coincides with a completing read cancels it, even from zero
    assign rsp_dec = bus.av_readdatavalid && (bus.pending != '0 || rd_done);
    assign bus.cmd_ready = state == IDLE && (bus.cmd_write || bus.pending < PEND_MAX);
    assign bus.busy = state == ISSUE || bus.pending != '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            bus.pending         <= '0;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_data        <= '0;
            bus.rsp_err         <= 1'b0;
            bus.av_address      <= '0;
            bus.av_byteenable_n <= '1;
            bus.av_chipselect   <= 1'b0;
            bus.av_writedata    <= '0;
            bus.av_read_n       <= 1'b1;
            bus.av_write_n      <= 1'b1;
        end else begin
            bus.rsp_valid <= bus.av_readdatavalid;
            if (bus.av_readdatavalid) bus.rsp_data <= bus.av_readdata;
            if (bus.av_readdatavalid && bus.pending == '0) bus.rsp_err <= 1'b1;
            bus.pending <= bus.pending + PW'(rd_done) - PW'(rsp_dec);
            if (state == IDLE && bus.cmd_valid && bus.cmd_ready) begin
                state               <= ISSUE;
                bus.av_address      <= bus.cmd_addr;
                bus.av_writedata    <= bus.cmd_wdata;
                bus.av_byteenable_n <= ~bus.cmd_be;
                bus.av_chipselect   <= 1'b1;
                bus.av_read_n       <= bus.cmd_write;
                bus.av_write_n      <= !bus.cmd_write;
            end else if (state == ISSUE && !bus.av_waitrequest) begin
                state             <= IDLE;
                bus.av_chipselect <= 1'b0;
                bus.av_read_n     <= 1'b1;
                bus.av_write_n    <= 1'b1;
            end
        end
    end
endmodule
